// File: rtl/data_ctrl_pkg.sv
// data_ctrl_pkg
//   Shared constants for the data controller: bus widths, the byte-count
//   encodings used on the store/load width inputs, and small helpers for
//   width normalisation and load-result extension.
package data_ctrl_pkg;

  localparam int AddressWidth = 32;
  localparam int IDWidth      = 32;

  // The width codes are one-hot byte counts, so a legal code doubles as
  // the number of bytes to transfer.
  localparam logic [2:0] WIDTH_BYTE = 3'b001;
  localparam logic [2:0] WIDTH_HALF = 3'b010;
  localparam logic [2:0] WIDTH_WORD = 3'b100;

  // Anything that is not a byte or half-word access is handled as a word.
  function automatic logic [2:0] norm_width(input logic [2:0] width);
    logic [2:0] result;
    case (width)
      WIDTH_BYTE: result = WIDTH_BYTE;
      WIDTH_HALF: result = WIDTH_HALF;
      default:    result = WIDTH_WORD;
    endcase
    return result;
  endfunction

  // Sign- or zero-extend the low 'width' bytes of an assembled load.
  function automatic logic [IDWidth-1:0] extend_load(input logic [IDWidth-1:0] raw,
                                                     input logic [2:0]         width,
                                                     input logic               sgn);
    logic [IDWidth-1:0] result;
    case (width)
      WIDTH_BYTE: result = {{(IDWidth-8){sgn & raw[7]}}, raw[7:0]};
      WIDTH_HALF: result = {{(IDWidth-16){sgn & raw[15]}}, raw[15:0]};
      default:    result = raw;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_ctrl_if.sv
// data_ctrl_if
//   Byte-wide RAM bus between the data controller and the memory.
//   mem_din_in   : read byte from RAM, valid one cycle after the address
//   mem_dout_out : write byte to RAM
//   mem_a_out    : byte address
//   mem_wr_out   : 1 = write, 0 = read
//   master = controller side, slave = memory side.
interface data_ctrl_if;
  import data_ctrl_pkg::*;

  logic [7:0]              mem_din_in;
  logic [7:0]              mem_dout_out;
  logic [AddressWidth-1:0] mem_a_out;
  logic                    mem_wr_out;

  modport master (
    input  mem_din_in,
    output mem_dout_out,
    output mem_a_out,
    output mem_wr_out
  );

  modport slave (
    output mem_din_in,
    input  mem_dout_out,
    input  mem_a_out,
    input  mem_wr_out
  );

endinterface

// File: rtl/data_ctrl.sv
// data_ctrl
//   Serialises committed stores (from the ROB) and loads (from the load
//   buffer) onto a byte-wide RAM bus. Stores have priority over loads.
//   Ports:
//     clk_in, rst_in (async, active-high), rdy_in (global enable)
//     rob_rst_in                 : flush pulse, aborts an in-flight load only
//     rob_datactrl_*_in          : store request (en level, addr, width, data)
//     datactrl_rob_en_out        : store-complete pulse
//     lbuffer_datactrl_*_in      : load request (en level, addr, width, signed)
//     datactrl_lbuffer_en_out    : load-complete pulse
//     datactrl_lbuffer_data_out  : extended load result, valid with the pulse
//     mem                        : RAM byte bus (master side)
module data_ctrl
  import data_ctrl_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_rst_in,
  input  logic                    rob_datactrl_en_in,
  input  logic [AddressWidth-1:0] rob_datactrl_addr_in,
  input  logic [2:0]              rob_datactrl_width_in,
  input  logic [IDWidth-1:0]      rob_datactrl_data_in,
  output logic                    datactrl_rob_en_out,
  input  logic                    lbuffer_datactrl_en_in,
  input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]              lbuffer_datactrl_width_in,
  input  logic                    lbuffer_datactrl_signed_in,
  output logic                    datactrl_lbuffer_en_out,
  output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
  data_ctrl_if.master             mem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [2:0]              cnt_reg;      // STORE: byte being driven; LOAD: bytes captured
  logic [2:0]              width_reg;    // normalised byte count (1, 2 or 4)
  logic                    signed_reg;
  logic [AddressWidth-1:0] addr_reg;
  logic [IDWidth-1:0]      data_reg;
  logic [IDWidth-1:0]      load_buf_reg;
  logic [AddressWidth-1:0] mem_a_reg;
  logic [7:0]              mem_dout_reg;
  logic                    mem_wr_reg;
  logic                    rob_done_reg;
  logic                    lb_done_reg;
  logic [IDWidth-1:0]      lb_data_reg;

  logic [2:0]              cnt_inc;
  logic                    last_byte;
  logic [IDWidth-1:0]      load_buf_next;
  logic [IDWidth-1:0]      load_ext;

  assign cnt_inc   = cnt_reg + 3'd1;
  assign last_byte = (cnt_inc == width_reg);

  // Load assembly: the byte arriving this cycle lands in lane cnt_reg, all
  // other lanes keep what was captured earlier. This lets the final edge
  // extend the complete value without an extra cycle.
  generate
    for (genvar gi = 0; gi < IDWidth/8; gi++) begin : g_load_lane
      assign load_buf_next[8*gi +: 8] = (cnt_reg[1:0] == 2'(gi)) ? mem.mem_din_in
                                                                  : load_buf_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_ext = extend_load(load_buf_next, width_reg, signed_reg);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      width_reg    <= WIDTH_WORD;
      signed_reg   <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
      load_buf_reg <= '0;
      mem_a_reg    <= '0;
      mem_dout_reg <= '0;
      mem_wr_reg   <= 1'b0;
      rob_done_reg <= 1'b0;
      lb_done_reg  <= 1'b0;
      lb_data_reg  <= '0;
    end else if (rdy_in) begin
      rob_done_reg <= 1'b0;
      lb_done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          mem_wr_reg <= 1'b0;
          mem_a_reg  <= '0;
          // A requester still sees its own done pulse this cycle and has
          // not yet dropped the request, so the matching pulse masks it.
          // The store is already committed and therefore ignores flushes.
          if (rob_datactrl_en_in && !rob_done_reg) begin
            addr_reg     <= rob_datactrl_addr_in;
            data_reg     <= rob_datactrl_data_in;
            width_reg    <= norm_width(rob_datactrl_width_in);
            mem_a_reg    <= rob_datactrl_addr_in;
            mem_dout_reg <= rob_datactrl_data_in[7:0];
            mem_wr_reg   <= 1'b1;
            cnt_reg      <= '0;
            state_reg    <= ST_STORE;
          end else if (lbuffer_datactrl_en_in && !lb_done_reg && !rob_rst_in) begin
            addr_reg     <= lbuffer_datactrl_addr_in;
            width_reg    <= norm_width(lbuffer_datactrl_width_in);
            signed_reg   <= lbuffer_datactrl_signed_in;
            load_buf_reg <= '0;
            mem_a_reg    <= lbuffer_datactrl_addr_in;
            mem_wr_reg   <= 1'b0;
            cnt_reg      <= '0;
            state_reg    <= ST_LOAD;
          end
        end

        ST_STORE: begin
          if (!last_byte) begin
            cnt_reg      <= cnt_inc;
            mem_a_reg    <= addr_reg + AddressWidth'(cnt_inc);
            mem_dout_reg <= data_reg[{cnt_inc[1:0], 3'b000} +: 8];
            mem_wr_reg   <= 1'b1;
          end else begin
            cnt_reg      <= '0;
            mem_a_reg    <= '0;
            mem_wr_reg   <= 1'b0;
            rob_done_reg <= 1'b1;
            state_reg    <= ST_IDLE;
          end
        end

        ST_LOAD: begin
          if (rob_rst_in) begin
            // Speculative load squashed: drop it silently.
            cnt_reg   <= '0;
            mem_a_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            load_buf_reg <= load_buf_next;
            if (last_byte) begin
              lb_data_reg <= load_ext;
              lb_done_reg <= 1'b1;
              cnt_reg     <= '0;
              mem_a_reg   <= '0;
              state_reg   <= ST_IDLE;
            end else begin
              cnt_reg   <= cnt_inc;
              mem_a_reg <= addr_reg + AddressWidth'(cnt_inc);
            end
          end
        end

        default: begin
          state_reg  <= ST_IDLE;
          mem_wr_reg <= 1'b0;
          mem_a_reg  <= '0;
        end
      endcase
    end
  end

  assign mem.mem_a_out             = mem_a_reg;
  assign mem.mem_dout_out          = mem_dout_reg;
  assign mem.mem_wr_out            = mem_wr_reg;
  assign datactrl_rob_en_out       = rob_done_reg;
  assign datactrl_lbuffer_en_out   = lb_done_reg;
  assign datactrl_lbuffer_data_out = lb_data_reg;

endmodule
